// File: rtl/div16_pkg.sv
`default_nettype none
// ============================================================================
// Package     : div16_pkg
// Description : Shared constants and the S0 pipeline-register layout for the
//               div16_pipe_ctrl stage and its helpers.
//               Optional feature macro used by the users of this package:
//               DIV16_PIPE_SIGNED_EN (two's-complement operands).
// Contents    : DATA_W    - operand / quotient width
//               DZ_QUOT   - quotient reported for a zero divisor
//               S0_TAG_W  - width of the tag field held in s0_t
//               s0_t      - S0 register: operands, sign, dz flag, tag
//               is_zero() - divisor-zero detect
// Revision    : 1.0 - initial release
// ============================================================================
package div16_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] DZ_QUOT = 16'hFFFF;
  localparam int S0_TAG_W = 4;

  // In signed builds a/b hold magnitudes and neg the quotient sign; in
  // unsigned builds a/b are the raw operands and neg is constant 0.
  typedef struct packed {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                neg;
    logic                dz;
    logic [S0_TAG_W-1:0] tag;
  } s0_t;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/DIV16.sv
`default_nettype none
// ============================================================================
// Module      : DIV16
// Description : Combinational 16-bit unsigned restoring divider.
//               A zero divisor yields an all-ones quotient, since every trial
//               subtraction succeeds.
// Ports       : a_i [15:0] in  - dividend
//               b_i [15:0] in  - divisor
//               q_o [15:0] out - floor(a_i / b_i)
// Revision    : 1.0 - initial release
// ============================================================================
module DIV16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] q_o
);

  // Partial remainder stays below 2*b, so 17 bits is always enough.
  logic [16:0] rem;

  always_comb begin
    rem = '0;
    q_o = '0;
    for (int i = 15; i >= 0; i--) begin
      rem = {rem[15:0], a_i[i]};
      if (rem >= {1'b0, b_i}) begin
        rem    = rem - {1'b0, b_i};
        q_o[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div16_sign_unit.sv
`default_nettype none
// ============================================================================
// Module      : div16_sign_unit
// Description : Combinational conditional two's-complement negate. Used as
//               abs() by tying neg_i to the operand MSB, and as the quotient
//               sign fix-up. Only instantiated when DIV16_PIPE_SIGNED_EN is
//               defined.
// Ports       : val_i [WIDTH-1:0] in  - input value
//               neg_i             in  - 1: negate, 0: pass through
//               val_o [WIDTH-1:0] out - result (wraps for the most negative)
// Revision    : 1.0 - initial release
// ============================================================================
module div16_sign_unit
  import div16_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  // -(16'h8000) == 16'h8000, which is exactly the unsigned magnitude of
  // the most negative value, so abs() needs no special case.
  assign val_o = neg_i ? (-val_i) : val_i;

endmodule
`default_nettype wire

// File: rtl/div16_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div16_pipe_ctrl
// Description : Two-stage valid/ready wrapper around the combinational DIV16
//               core. S0 registers operands, tag, dz flag (and sign info);
//               DIV16 sits between S0 and S1; S1 registers quotient, dz and
//               tag. Sustains one division per cycle.
//               Optional macro DIV16_PIPE_SIGNED_EN: two's-complement
//               operands, quotient truncated toward zero.
// Parameters  : TAG_W - sideband tag width (must match div16_pkg::S0_TAG_W)
// Ports       : clk        in   - clock, rising edge
//               rst        in   - synchronous active-high reset
//               in_valid   in   - operand pair valid
//               in_ready   out  - stage accepts operands this cycle
//               in_a [15:0] in  - dividend
//               in_b [15:0] in  - divisor
//               in_tag     in   - sideband tag
//               out_valid  out  - result valid
//               out_ready  in   - consumer accepts result this cycle
//               out_q [15:0] out - quotient (16'hFFFF on zero divisor)
//               out_dz     out  - divisor was zero
//               out_tag    out  - tag of this result
// Revision    : 1.0 - initial release
// ============================================================================
module div16_pipe_ctrl
  import div16_pkg::*;
#(
  parameter int TAG_W = S0_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q,
  output logic              out_dz,
  output logic [TAG_W-1:0]  out_tag
);

  s0_t               s0_q;
  s0_t               s0_d;
  logic              s0_valid_q;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_quot_q;
  logic [DATA_W-1:0] s1_quot_d;
  logic              s1_dz_q;
  logic [TAG_W-1:0]  s1_tag_q;

  logic              s0_adv;
  logic              s1_adv;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              neg_d;
  logic [DATA_W-1:0] core_q;
  logic [DATA_W-1:0] quot_res;

  // Handshake: a stage may load when it is empty or its content moves on.
  // in_ready depends only on state and out_ready, never on in_valid.
  assign s1_adv   = !s1_valid_q || out_ready;
  assign s0_adv   = !s0_valid_q || s1_adv;
  assign in_ready = s0_adv;

`ifdef DIV16_PIPE_SIGNED_EN
  if (1'b1) begin : g_signed
    div16_sign_unit #(.WIDTH(DATA_W)) u_abs_a (
      .val_i (in_a),
      .neg_i (in_a[DATA_W-1]),
      .val_o (a_mag)
    );

    div16_sign_unit #(.WIDTH(DATA_W)) u_abs_b (
      .val_i (in_b),
      .neg_i (in_b[DATA_W-1]),
      .val_o (b_mag)
    );

    div16_sign_unit #(.WIDTH(DATA_W)) u_neg_q (
      .val_i (core_q),
      .neg_i (s0_q.neg),
      .val_o (quot_res)
    );

    assign neg_d = in_a[DATA_W-1] ^ in_b[DATA_W-1];
  end
`else
  if (1'b1) begin : g_unsigned
    logic unused_neg;

    assign a_mag      = in_a;
    assign b_mag      = in_b;
    assign neg_d      = 1'b0;
    assign quot_res   = core_q;
    // The sign bit is constant 0 here and gets optimised away.
    assign unused_neg = s0_q.neg;
  end
`endif

  always_comb begin
    s0_d     = '0;
    s0_d.a   = a_mag;
    s0_d.b   = b_mag;
    s0_d.neg = neg_d;
    s0_d.dz  = is_zero(in_b);
    s0_d.tag = in_tag;
  end

  DIV16 u_div16 (
    .a_i (s0_q.a),
    .b_i (s0_q.b),
    .q_o (core_q)
  );

  // Zero divisor reports DZ_QUOT regardless of sign handling.
  assign s1_quot_d = s0_q.dz ? DZ_QUOT : quot_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_quot_q  <= '0;
      s1_dz_q    <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      if (s0_adv) begin
        s0_valid_q <= in_valid;
        if (in_valid) begin
          s0_q <= s0_d;
        end
      end
      // Data registers only load on a real transfer, so a stalled result
      // stays put and an emptied stage keeps its last value harmlessly.
      if (s1_adv) begin
        s1_valid_q <= s0_valid_q;
        if (s0_valid_q) begin
          s1_quot_q <= s1_quot_d;
          s1_dz_q   <= s0_q.dz;
          s1_tag_q  <= s0_q.tag;
        end
      end
    end
  end

  assign out_valid = s1_valid_q;
  assign out_q     = s1_quot_q;
  assign out_dz    = s1_dz_q;
  assign out_tag   = s1_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_div16_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div16_pipe_ctrl
// Description : Self-checking bench for div16_pipe_ctrl. A queue of expected
//               results (arithmetic reference) tracks what is in flight;
//               occupancy and acceptance age give the expected handshake.
//               Define DIV16_PIPE_SIGNED_EN to exercise the signed build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div16_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic        out_dz;
  logic [3:0]  out_tag;

  div16_pipe_ctrl #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_dz    (out_dz),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic        dz;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          vectors;
  int          miscompares;
  int          cyc;
  logic        held_vld;
  logic [15:0] held_q;
  logic        held_dz;
  logic [3:0]  held_tag;
  logic [15:0] last_q;
  logic        last_dz;
  logic [3:0]  last_tag;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, expv);
    end
  endtask

  // Reference: quotient by plain arithmetic, dz for zero divisor.
  function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sbv;
    int qi;
    logic [16:0] r;
    if (b == 16'd0) begin
      r = {1'b1, 16'hFFFF};
    end else begin
`ifdef DIV16_PIPE_SIGNED_EN
      sa  = $signed(a);
      sbv = $signed(b);
      qi  = sa / sbv;
`else
      sa  = int'(a);
      sbv = int'(b);
      qi  = sa / sbv;
`endif
      r = {1'b0, qi[15:0]};
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd_b();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h0000;
      1:       v = 16'h0001;
      2:       v = 16'hFFFF;
      3:       v = 16'($urandom_range(1, 15));
      4:       v = 16'h8000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, check after settling,
  // update the model, then advance to the next falling edge.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] t, input logic ordy, output logic acc);
    exp_t        e;
    logic [16:0] r;
    logic        exp_ov;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'((sb.size() < 2) || ordy));
    exp_ov = 1'b0;
    if (sb.size() > 0) exp_ov = (cyc >= sb[0].acc + 2);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (held_vld) begin
      chk("hold_q", 32'(out_q), 32'(held_q));
      chk("hold_dz", 32'(out_dz), 32'(held_dz));
      chk("hold_tag", 32'(out_tag), 32'(held_tag));
      held_vld = 1'b0;
    end
    if (out_valid && ordy && sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_q", 32'(out_q), 32'(e.q));
      chk("res_dz", 32'(out_dz), 32'(e.dz));
      chk("res_tag", 32'(out_tag), 32'(e.tag));
      last_q   = out_q;
      last_dz  = out_dz;
      last_tag = out_tag;
    end else if (out_valid && !ordy) begin
      held_vld = 1'b1;
      held_q   = out_q;
      held_dz  = out_dz;
      held_tag = out_tag;
    end
    acc = v && in_ready;
    if (acc) begin
      r     = ref_div(a, b);
      e.q   = r[15:0];
      e.dz  = r[16];
      e.tag = t;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    logic acc;
    int   n;
    n = 0;
    while (sb.size() > 0 && n < max_cyc) begin
      cycle(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, acc);
      n++;
    end
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_dz", 32'(out_dz), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    sb.delete();
    held_vld = 1'b0;
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    int          idx;
    int          n;
    logic [15:0] sa_arr [4];
    logic [15:0] sb_arr [4];
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    held_vld    = 1'b0;
    last_q      = '0;
    last_dz     = 1'b0;
    last_tag    = '0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_tag      = '0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    do_reset();

    // 100 / 7, tag 3, two-cycle latency
    cycle(1'b1, 16'd100, 16'd7, 4'd3, 1'b1, acc);
    chk("t1_accept", 32'(acc), 32'd1);
    drain(10);
    chk("t1_q", 32'(last_q), 32'd14);
    chk("t1_dz", 32'(last_dz), 32'd0);
    chk("t1_tag", 32'(last_tag), 32'd3);

    // Divide by zero
    cycle(1'b1, 16'd5, 16'd0, 4'd9, 1'b1, acc);
    drain(10);
    chk("dz_q", 32'(last_q), 32'hFFFF);
    chk("dz_flag", 32'(last_dz), 32'd1);

    // Eight back-to-back ops at full throughput
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'($urandom), rnd_b(), 4'(i), 1'b1, acc);
      chk("b2b_accept", 32'(acc), 32'd1);
    end
    drain(10);

    // Stall: only two ops fit, outputs hold, then all three drain in order
    for (int i = 0; i < 3; i++) begin
      sa_arr[i] = 16'($urandom);
      sb_arr[i] = rnd_b();
    end
    sa_arr[3] = '0;
    sb_arr[3] = '0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(idx < 3, sa_arr[idx], sb_arr[idx], 4'(idx + 4), 1'b0, acc);
      if (acc) idx++;
    end
    chk("stall_accepted", 32'(idx), 32'd2);
    n = 0;
    while ((idx < 3 || sb.size() > 0) && n < 20) begin
      cycle(idx < 3, sa_arr[idx], sb_arr[idx], 4'(idx + 4), 1'b1, acc);
      if (acc) idx++;
      n++;
    end
    chk("stall_all_sent", 32'(idx), 32'd3);
    chk("stall_drained", 32'(sb.size()), 32'd0);

    // Reset with two ops in flight: nothing from them may appear
    cycle(1'b1, 16'd1000, 16'd3, 4'd1, 1'b0, acc);
    cycle(1'b1, 16'd2000, 16'd7, 4'd2, 1'b0, acc);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, acc);

`ifdef DIV16_PIPE_SIGNED_EN
    cycle(1'b1, 16'hFF9C, 16'd7, 4'd1, 1'b1, acc);
    drain(10);
    chk("s_m100_7", 32'(last_q), 32'hFFF2);
    cycle(1'b1, 16'h8000, 16'hFFFF, 4'd2, 1'b1, acc);
    drain(10);
    chk("s_min_m1", 32'(last_q), 32'h8000);
    chk("s_min_m1_dz", 32'(last_dz), 32'd0);
    cycle(1'b1, 16'd7, 16'hFFFE, 4'd3, 1'b1, acc);
    drain(10);
    chk("s_7_m2", 32'(last_q), 32'hFFFD);
`endif

    // Random soak with random handshake on both sides
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), rnd_b(),
            4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc);
    end
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
